// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the 16-register bus datapath; outputs decode state+IR in the same cycle.
// One control step per Clock edge; Stop is latched and only honoured where the sequence would re-enter T0.
module control_sequencer #(
  parameter int unsigned RESET_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        IRin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighin,
  output logic        ZLowin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        PCout,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        Read,
  output logic        IncPC,
  output logic [4:0]  OP,
  output logic        Run,
  output logic        Illegal,
  output logic [3:0]  Step
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    T6     = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT,
    C_ILL
  } iclass_t;

  localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES);

  state_t     state, state_nxt;
  iclass_t    cls;
  logic [3:0] rst_cnt;
  logic       stop_pend;
  state_t     fetch_nxt;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic [4:0] alu_op;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign alu_op    = opc + 5'd1;
  assign unused_ir = ^IR[14:0];

  function automatic logic [15:0] sel16(input logic [3:0] n);
    sel16 = 16'd1 << n;
  endfunction

  always_comb begin
    cls = C_ILL;
    if (opc inside {[5'd3:5'd10]})
      cls = C_ALU;
    else if (opc inside {5'd14, 5'd15})
      cls = C_MULDIV;
    else if (opc inside {5'd16, 5'd17})
      cls = C_UNARY;
    else if (opc == 5'd26)
      cls = C_NOP;
    else if (opc == 5'd27)
      cls = C_HALT;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= S_RST;
      rst_cnt   <= RST_LOAD;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_RST && rst_cnt != 4'd1)
        rst_cnt <= rst_cnt - 4'd1;
      // A Stop seen mid-instruction is held until the instruction boundary
      if (Stop && state != S_HALT)
        stop_pend <= 1'b1;
    end
  end

  assign fetch_nxt = (Stop || stop_pend) ? S_HALT : T0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  if (rst_cnt == 4'd1) state_nxt = fetch_nxt;
      T0:     state_nxt = T1;
      T1:     state_nxt = T2;
      T2:     state_nxt = T3;
      T3: begin
        case (cls)
          C_ALU, C_MULDIV, C_UNARY: state_nxt = T4;
          C_HALT:                   state_nxt = S_HALT;
          default:                  state_nxt = fetch_nxt;
        endcase
      end
      T4:     state_nxt = (cls == C_UNARY) ? fetch_nxt : T5;
      T5:     state_nxt = (cls == C_MULDIV) ? T6 : fetch_nxt;
      T6:     state_nxt = fetch_nxt;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    Rin      = '0;
    Rout     = '0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighin  = 1'b0;
    ZLowin   = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    Yin      = 1'b0;
    PCout    = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    ZHighout = 1'b0;
    ZLowout  = 1'b0;
    MDRout   = 1'b0;
    Read     = 1'b0;
    IncPC    = 1'b0;
    OP       = '0;
    Illegal  = 1'b0;
    Step     = state;
    Run      = (state != S_RST) && (state != S_HALT);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        PCin  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        case (cls)
          C_ALU: begin
            Rout = sel16(rb);
            Yin  = 1'b1;
          end
          C_MULDIV: begin
            Rout = sel16(ra);
            Yin  = 1'b1;
          end
          C_UNARY: begin
            Rout   = sel16(rb);
            OP     = alu_op;
            ZLowin = 1'b1;
          end
          C_ILL:   Illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_ALU: begin
            Rout   = sel16(rc);
            OP     = alu_op;
            ZLowin = 1'b1;
          end
          C_MULDIV: begin
            Rout    = sel16(rb);
            OP      = alu_op;
            ZHighin = 1'b1;
            ZLowin  = 1'b1;
          end
          C_UNARY: begin
            ZLowout = 1'b1;
            Rin     = sel16(ra);
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_ALU: begin
            ZLowout = 1'b1;
            Rin     = sel16(ra);
          end
          C_MULDIV: begin
            ZLowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (cls == C_MULDIV) begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-cycle expected strobes queued by stimulus, compared by a negedge monitor.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, irin, hiin, loin, zhighin, zlowin, marin, mdrin, yin;
    logic pcout, hiout, loout, zhighout, zlowout, mdrout, read, incpc;
    logic [4:0] op;
    logic run, illegal;
    logic [3:0] step;
  } snap_t;

  logic        Clock = 1'b0;
  logic        Clear1, Clear3, Stop;
  logic [31:0] IR;

  logic [15:0] rin1, rout1, rin3, rout3;
  logic pcin1, irin1, hiin1, loin1, zhighin1, zlowin1, marin1, mdrin1, yin1;
  logic pcout1, hiout1, loout1, zhighout1, zlowout1, mdrout1, read1, incpc1;
  logic pcin3, irin3, hiin3, loin3, zhighin3, zlowin3, marin3, mdrin3, yin3;
  logic pcout3, hiout3, loout3, zhighout3, zlowout3, mdrout3, read3, incpc3;
  logic [4:0] op1, op3;
  logic run1, illegal1, run3, illegal3;
  logic [3:0] step1, step3;
  snap_t act1, act3;

  control_sequencer #(.RESET_CYCLES(1)) u_dut1 (
    .Clock(Clock), .Clear(Clear1), .IR(IR), .Stop(Stop),
    .Rin(rin1), .Rout(rout1), .PCin(pcin1), .IRin(irin1), .HIin(hiin1), .LOin(loin1),
    .ZHighin(zhighin1), .ZLowin(zlowin1), .MARin(marin1), .MDRin(mdrin1), .Yin(yin1),
    .PCout(pcout1), .HIout(hiout1), .LOout(loout1), .ZHighout(zhighout1), .ZLowout(zlowout1),
    .MDRout(mdrout1), .Read(read1), .IncPC(incpc1), .OP(op1), .Run(run1),
    .Illegal(illegal1), .Step(step1)
  );

  control_sequencer #(.RESET_CYCLES(3)) u_dut3 (
    .Clock(Clock), .Clear(Clear3), .IR(IR), .Stop(Stop),
    .Rin(rin3), .Rout(rout3), .PCin(pcin3), .IRin(irin3), .HIin(hiin3), .LOin(loin3),
    .ZHighin(zhighin3), .ZLowin(zlowin3), .MARin(marin3), .MDRin(mdrin3), .Yin(yin3),
    .PCout(pcout3), .HIout(hiout3), .LOout(loout3), .ZHighout(zhighout3), .ZLowout(zlowout3),
    .MDRout(mdrout3), .Read(read3), .IncPC(incpc3), .OP(op3), .Run(run3),
    .Illegal(illegal3), .Step(step3)
  );

  assign act1 = {rin1, rout1, pcin1, irin1, hiin1, loin1, zhighin1, zlowin1, marin1, mdrin1, yin1,
                 pcout1, hiout1, loout1, zhighout1, zlowout1, mdrout1, read1, incpc1,
                 op1, run1, illegal1, step1};
  assign act3 = {rin3, rout3, pcin3, irin3, hiin3, loin3, zhighin3, zlowin3, marin3, mdrin3, yin3,
                 pcout3, hiout3, loout3, zhighout3, zlowout3, mdrout3, read3, incpc3,
                 op3, run3, illegal3, step3};

  always #5 Clock = ~Clock;

  snap_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    sel = 1'b0;
  bit    stop_seen = 1'b0;
  snap_t mon_exp, mon_act;
  string mon_tag;

  // Monitor: one expected snapshot per sampled cycle of the selected DUT
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = sel ? act3 : act1;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %h (step %0d) expected %h (step %0d)",
                 mon_tag, mon_act, mon_act.step, mon_exp, mon_exp.step);
      end
    end
  end

  // Reference model: strobes for step k (0 = T0) of instruction ir, read off the instruction tables
  function automatic int instr_len(input logic [4:0] opc);
    if (opc >= 5'd3 && opc <= 5'd10) return 6;
    if (opc == 5'd14 || opc == 5'd15) return 7;
    if (opc == 5'd16 || opc == 5'd17) return 5;
    return 4;
  endfunction

  function automatic snap_t model(input logic [31:0] ir, input int k);
    snap_t s;
    logic [4:0] opc;
    int ra, rb, rc;
    s   = '0;
    opc = ir[31:27];
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    s.run  = 1'b1;
    s.step = 4'(k + 1);
    if (k == 0) begin s.pcout = 1; s.marin = 1; s.incpc = 1; end
    else if (k == 1) begin s.pcin = 1; s.read = 1; s.mdrin = 1; end
    else if (k == 2) begin s.mdrout = 1; s.irin = 1; end
    else if (opc >= 5'd3 && opc <= 5'd10) begin
      if (k == 3) begin s.rout[rb] = 1; s.yin = 1; end
      if (k == 4) begin s.rout[rc] = 1; s.op = opc + 5'd1; s.zlowin = 1; end
      if (k == 5) begin s.zlowout = 1; s.rin[ra] = 1; end
    end else if (opc == 5'd14 || opc == 5'd15) begin
      if (k == 3) begin s.rout[ra] = 1; s.yin = 1; end
      if (k == 4) begin s.rout[rb] = 1; s.op = opc + 5'd1; s.zhighin = 1; s.zlowin = 1; end
      if (k == 5) begin s.zlowout = 1; s.loin = 1; end
      if (k == 6) begin s.zhighout = 1; s.hiin = 1; end
    end else if (opc == 5'd16 || opc == 5'd17) begin
      if (k == 3) begin s.rout[rb] = 1; s.op = opc + 5'd1; s.zlowin = 1; end
      if (k == 4) begin s.zlowout = 1; s.rin[ra] = 1; end
    end else if (opc != 5'd26 && opc != 5'd27) begin
      s.illegal = 1'b1;
    end
    return s;
  endfunction

  function automatic snap_t halt_snap();
    snap_t s;
    s      = '0;
    s.step = 4'd8;
    return s;
  endfunction

  task automatic expect_cycle(input snap_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge Clock);
    #1;
  endtask

  task automatic set_clear(input logic v);
    if (sel) Clear3 = v;
    else     Clear1 = v;
  endtask

  task automatic do_reset(input int hold, input int rc);
    set_clear(1'b0);
    stop_seen = 1'b0;
    repeat (hold) expect_cycle('0, "reset_hold");
    set_clear(1'b1);
    repeat (rc) expect_cycle('0, "reset_count");
  endtask

  task automatic run_instr(input logic [31:0] ir, input int stop_k, input int abort_k, input string t);
    int len;
    len = instr_len(ir[31:27]);
    for (int k = 0; k < len; k++) begin
      if (k == 3) IR = ir;
      if (k == abort_k) begin
        set_clear(1'b0);
        stop_seen = 1'b0;
        Stop = 1'b0;
        expect_cycle('0, {t, "/abort"});
        return;
      end
      Stop = (k == stop_k);
      if (Stop) stop_seen = 1'b1;
      expect_cycle(model(ir, k), $sformatf("%s/T%0d", t, k));
    end
    Stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ropc;
    logic [31:0] rir;
    Clear1 = 1'b1;
    Clear3 = 1'b1;
    IR     = '0;
    Stop   = 1'b0;
    #2;
    Clear1 = 1'b0;
    Clear3 = 1'b0;
    @(posedge Clock);
    #1;

    do_reset(3, 1);
    run_instr(32'h18228000, -1, -1, "add");
    run_instr(32'h71180000, -1, -1, "mul");
    run_instr(32'hF8000000, -1, -1, "illegal");
    run_instr({5'd26, 27'h5A5A5A5}, -1, -1, "nop");
    run_instr({5'd15, 4'd9, 4'd12, 19'h0}, -1, -1, "div");
    run_instr({5'd17, 4'd15, 4'd1, 19'h0}, -1, -1, "not");
    for (int i = 0; i < 40; i++) begin
      ropc = 5'($urandom_range(0, 31));
      if (ropc == 5'd27) ropc = 5'd26;
      rir = {ropc, 27'($urandom)};
      run_instr(rir, -1, -1, $sformatf("rand%0d", i));
    end

    run_instr(32'h18228000, 4, -1, "add_stop");
    repeat (6) expect_cycle(halt_snap(), "stop_halted");

    do_reset(2, 1);
    run_instr({5'd16, 4'd7, 4'd2, 19'h0}, -1, -1, "neg");
    run_instr({5'd27, 27'h0}, -1, -1, "halt");
    repeat (20) expect_cycle(halt_snap(), "halt_opc");

    sel = 1'b1;
    do_reset(2, 3);
    run_instr(32'h18228000, -1, 4, "add_abort");
    do_reset(1, 3);
    run_instr(32'h18228000, -1, -1, "add_after_abort");
    run_instr(32'h71180000, -1, -1, "mul_after_abort");

    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
